sigmoid_plan_pipe: RTL and testbench

Parametrised, pipelined piecewise-linear (PLAN-style) activation unit. It succeeds the fixed 8-bit/16-bit sigmoid block with:
- configurable input and output widths;
- a per-sample sigmoid/tanh mode;
- valid/ready backpressure on both sides.

It sits between the MAC accumulator and the activation writeback. It keeps the 51-bit transistor-count reporting port used throughout the datapath.

---
 rtl/sigmoid_pkg.sv | 44 ++++
 rtl/sigmoid_pwl_seg.sv | 48 ++++
 rtl/sigmoid_reg_cell.sv | 26 ++
 rtl/sigmoid_plan_pipe.sv | 153 +++++++++++++++
 tb/tb_sigmoid_plan_pipe.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sigmoid_pkg.sv
// Shared types and constants for the piecewise-linear sigmoid/tanh pipeline.
// Intercepts are stored in eighths so every stage can rescale them with a shift.
package sigmoid_pkg;

    typedef enum logic [1:0] {
        R_LT1,
        R_LT2,
        R_LE4
    } region_e;

    typedef enum logic {
        MODE_SIG,
        MODE_TANH
    } mode_e;

    // Segment breakpoints in integer units of the input format.
    localparam int unsigned BP_1 = 1;
    localparam int unsigned BP_2 = 2;
    localparam int unsigned BP_4 = 4;

    // Per-segment slope as a right shift (a/4, a/8, a/16).
    localparam int unsigned SH_LT1 = 2;
    localparam int unsigned SH_LT2 = 3;
    localparam int unsigned SH_LE4 = 4;

    // Intercepts 0.5, 0.625, 0.75 expressed in units of 2^-ICPT_FRAC.
    localparam int unsigned ICPT_FRAC = 3;
    localparam int unsigned ICPT_LT1  = 4;
    localparam int unsigned ICPT_LT2  = 5;
    localparam int unsigned ICPT_LE4  = 6;

    localparam int unsigned NUM_W = 51;

    // Transistor counts of the library cells used to build the datapath.
    localparam int unsigned TC_DFF_BIT = 28;
    localparam int unsigned TC_FA_BIT  = 28;
    localparam int unsigned TC_MUX_BIT = 12;
    localparam int unsigned TC_DECODE  = 24;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sigmoid_pwl_seg.sv
// Combinational segment evaluator: p = intercept + magnitude >> slope, exact at PREC
// fraction bits. The slope is applied as a left shift of the rescaled magnitude.
module sigmoid_pwl_seg
    import sigmoid_pkg::*;
#(
    parameter int unsigned IN_W = 8,
    parameter int unsigned PREC = 15
) (
    input  logic [IN_W-1:0]  mag,
    input  region_e          region,
    output logic [PREC:0]    p,
    output logic [NUM_W-1:0] number
);

    localparam int unsigned FracIn = IN_W - 3;
    localparam int unsigned PW     = PREC + 1;

    logic [PW-1:0] mag_ext;
    logic [PW-1:0] slope_term;
    logic [PW-1:0] icpt;

    assign mag_ext = {{(PW - IN_W){1'b0}}, mag};

    // PREC >= FracIn + 4, so every segment shift is a non-negative left shift.
    always_comb begin
        slope_term = '0;
        icpt       = '0;
        case (region)
            R_LT1: begin
                slope_term = mag_ext << (PREC - FracIn - SH_LT1);
                icpt       = PW'(ICPT_LT1) << (PREC - ICPT_FRAC);
            end
            R_LT2: begin
                slope_term = mag_ext << (PREC - FracIn - SH_LT2);
                icpt       = PW'(ICPT_LT2) << (PREC - ICPT_FRAC);
            end
            default: begin
                slope_term = mag_ext << (PREC - FracIn - SH_LE4);
                icpt       = PW'(ICPT_LE4) << (PREC - ICPT_FRAC);
            end
        endcase
    end

    assign p = icpt + slope_term;

    assign number = NUM_W'(PW * TC_FA_BIT + 2 * PW * TC_MUX_BIT + TC_DECODE);

endmodule

// File: rtl/sigmoid_reg_cell.sv
// Parametrised enable register with synchronous active-low clear to zero.
// Reports its own transistor count so the top can total the datapath.
module sigmoid_reg_cell
    import sigmoid_pkg::*;
#(
    parameter int unsigned W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [W-1:0]     d,
    output logic [W-1:0]     q,
    output logic [NUM_W-1:0] number
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

    assign number = NUM_W'(W) * NUM_W'(TC_DFF_BIT);

endmodule

// File: rtl/sigmoid_plan_pipe.sv
// Three-stage PLAN sigmoid/tanh unit with valid/ready on both sides and
// collapsing bubbles. Mode travels with each sample.
module sigmoid_plan_pipe
    import sigmoid_pkg::*;
#(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [IN_W-1:0]  i_x,
    input  logic             i_mode,
    output logic [OUT_W-1:0] o_y,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [NUM_W-1:0] number
);

    localparam int unsigned FracIn = IN_W - 3;
    localparam int unsigned F      = OUT_W - 1;
    localparam int unsigned Prec   = max_u(FracIn + 4, F);
    localparam int unsigned W1     = IN_W + 4;
    localparam int unsigned W2     = Prec + 3;

    logic v1, v2, v3;
    logic en1, en2, en3;
    logic in_fire;

    assign en3         = !v3 || i_out_ready;
    assign en2         = !v2 || en3;
    assign en1         = !v1 || en2;
    assign o_in_ready  = rst_n && en1;
    assign o_out_valid = v3;
    assign in_fire     = i_in_valid && o_in_ready;

    // S1: magnitude, sign, region. Tanh doubles the magnitude and clamps at 4 (p = 1.0).
    logic            neg_d;
    logic [IN_W-1:0] abs_x;
    logic [IN_W:0]   dbl;
    logic [IN_W-1:0] mag_d;
    region_e         region_d;

    always_comb begin
        neg_d = i_x[IN_W-1];
        abs_x = neg_d ? (~i_x + IN_W'(1)) : i_x;
        dbl   = {abs_x, 1'b0};
        mag_d = abs_x;
        if (mode_e'(i_mode) == MODE_TANH) begin
            if (dbl >= ((IN_W + 1)'(BP_4) << FracIn)) begin
                mag_d = IN_W'(BP_4) << FracIn;
            end else begin
                mag_d = dbl[IN_W-1:0];
            end
        end
        if (mag_d < (IN_W'(BP_1) << FracIn)) begin
            region_d = R_LT1;
        end else if (mag_d < (IN_W'(BP_2) << FracIn)) begin
            region_d = R_LT2;
        end else begin
            region_d = R_LE4;
        end
    end

    logic [W1-1:0] s1_q;
    logic [NUM_W-1:0] num_v1, num_v2, num_v3, num_s1, num_s2, num_s3, num_seg;

    sigmoid_reg_cell #(.W(1)) u_v1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en1),
        .d      (in_fire),
        .q      (v1),
        .number (num_v1)
    );

    sigmoid_reg_cell #(.W(W1)) u_s1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (in_fire),
        .d      ({mag_d, neg_d, region_d, i_mode}),
        .q      (s1_q),
        .number (num_s1)
    );

    // S2: segment evaluation.
    logic [Prec:0] p_seg;

    sigmoid_pwl_seg #(.IN_W(IN_W), .PREC(Prec)) u_seg (
        .mag    (s1_q[W1-1:4]),
        .region (region_e'(s1_q[2:1])),
        .p      (p_seg),
        .number (num_seg)
    );

    logic [W2-1:0] s2_q;

    sigmoid_reg_cell #(.W(1)) u_v2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en2),
        .d      (v1),
        .q      (v2),
        .number (num_v2)
    );

    sigmoid_reg_cell #(.W(W2)) u_s2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en2 && v1),
        .d      ({p_seg, s1_q[3], s1_q[0]}),
        .q      (s2_q),
        .number (num_s2)
    );

    // S3: reflect, floor to F bits, tanh = 2*y_s - 1 with saturation at +1.
    logic [Prec:0]    ys_full;
    logic [OUT_W-1:0] ys;
    logic [OUT_W:0]   tw;
    logic [OUT_W-1:0] y_d;

    always_comb begin
        ys_full = s2_q[1] ? (((Prec + 1)'(1) << Prec) - s2_q[W2-1:2]) : s2_q[W2-1:2];
        ys      = OUT_W'(ys_full >> (Prec - F));
        tw      = {ys, 1'b0} - ((OUT_W + 1)'(1) << F);
        y_d     = ys;
        if (mode_e'(s2_q[0]) == MODE_TANH) begin
            y_d = ys[F] ? {1'b0, {F{1'b1}}} : OUT_W'(tw);
        end
    end

    sigmoid_reg_cell #(.W(1)) u_v3 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en3),
        .d      (v2),
        .q      (v3),
        .number (num_v3)
    );

    sigmoid_reg_cell #(.W(OUT_W)) u_s3 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en3 && v2),
        .d      (y_d),
        .q      (o_y),
        .number (num_s3)
    );

    assign number = num_v1 + num_v2 + num_v3 + num_s1 + num_s2 + num_s3 + num_seg;

endmodule

// File: tb/tb_sigmoid_plan_pipe.sv
// Directed and swept checks for sigmoid_plan_pipe at IN_W=8, OUT_W=16.
module tb_sigmoid_plan_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_in_valid;
    logic        o_in_ready;
    logic [7:0]  i_x;
    logic        i_mode;
    logic [15:0] o_y;
    logic        o_out_valid;
    logic        i_out_ready;
    logic [50:0] number;

    sigmoid_plan_pipe #(.IN_W(8), .OUT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_x         (i_x),
        .i_mode      (i_mode),
        .o_y         (o_y),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .number      (number)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  x;
        logic        mode;
        logic [15:0] y;
    } vec_t;

    vec_t        vecs [11];
    logic [15:0] sb [$];
    logic [15:0] out_log [$];
    int          out_cyc [$];
    int          checks = 0;
    int          errors = 0;
    int          cyc_n  = 0;
    int          n_out  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Real-valued reference: exact PWL value, then floor to 15 fraction bits.
    function automatic logic [15:0] model(input logic [7:0] x, input logic m);
        int  xi;
        real xr, a, p, y;
        int  ys, t;
        xi = int'($signed(x));
        xr = xi / 32.0;
        if (m) xr = 2.0 * xr;
        a = (xr < 0.0) ? -xr : xr;
        if (a >= 4.0)      p = 1.0;
        else if (a < 1.0)  p = 0.5 + a / 4.0;
        else if (a < 2.0)  p = 0.625 + a / 8.0;
        else               p = 0.75 + a / 16.0;
        y  = (xr < 0.0) ? 1.0 - p : p;
        ys = $rtoi($floor(y * 32768.0));
        if (!m) return 16'(ys);
        t = 2 * ys - 32768;
        if (t > 32767) t = 32767;
        return 16'(t);
    endfunction

    // One clock: observe transfers at the falling edge, then step past the rising edge.
    task automatic cyc(output logic acc);
        logic [15:0] e;
        @(negedge clk);
        acc = i_in_valid && o_in_ready;
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (o_out_valid && i_out_ready) begin
                n_out++;
                out_log.push_back(o_y);
                out_cyc.push_back(cyc_n);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_stale: got y=%h, no sample outstanding", o_y);
                end else begin
                    e = sb.pop_front();
                    check("sb_value", {16'h0, o_y}, {16'h0, e});
                end
            end
            if (acc) sb.push_back(model(i_x, i_mode));
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic send(input logic [7:0] x, input logic m);
        logic ok;
        int   guard;
        i_x        = x;
        i_mode     = m;
        i_in_valid = 1'b1;
        guard      = 0;
        do begin
            cyc(ok);
            guard++;
        end while (!ok && guard < 50);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no accept, expected accept within 50 cycles");
        end
    endtask

    task automatic drain();
        logic acc;
        int   g;
        i_in_valid = 1'b0;
        g = 0;
        while ((sb.size() != 0 || o_out_valid) && g < 100) begin
            cyc(acc);
            g++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        logic        acc;
        int          lat;
        int          n0;
        int          nv;
        logic [15:0] bp_x [5];
        logic [15:0] bp_y [5];
        logic [15:0] alt_y [4];

        vecs[0]  = '{x: 8'h00, mode: 1'b0, y: 16'h4000};
        vecs[1]  = '{x: 8'h20, mode: 1'b0, y: 16'h6000};
        vecs[2]  = '{x: 8'hE0, mode: 1'b0, y: 16'h2000};
        vecs[3]  = '{x: 8'h40, mode: 1'b0, y: 16'h7000};
        vecs[4]  = '{x: 8'h7F, mode: 1'b0, y: 16'h7FC0};
        vecs[5]  = '{x: 8'h80, mode: 1'b0, y: 16'h0000};
        vecs[6]  = '{x: 8'hFF, mode: 1'b0, y: 16'h3F00};
        vecs[7]  = '{x: 8'h10, mode: 1'b1, y: 16'h4000};
        vecs[8]  = '{x: 8'h40, mode: 1'b1, y: 16'h7FFF};
        vecs[9]  = '{x: 8'hC0, mode: 1'b1, y: 16'h8000};
        vecs[10] = '{x: 8'h00, mode: 1'b1, y: 16'h0000};
        bp_x  = '{16'h00, 16'h20, 16'hE0, 16'h40, 16'h80};
        bp_y  = '{16'h4000, 16'h6000, 16'h2000, 16'h7000, 16'h0000};
        alt_y = '{16'h5000, 16'h4000, 16'h5000, 16'h4000};

        rst_n       = 1'b0;
        i_in_valid  = 1'b0;
        i_x         = '0;
        i_mode      = 1'b0;
        i_out_ready = 1'b1;
        repeat (3) cyc(acc);
        check("rst_out_valid", o_out_valid, 0);
        check("rst_y", o_y, 0);
        check("rst_in_ready_low", o_in_ready, 0);
        rst_n = 1'b1;
        #1;
        check("rst_release_in_ready", o_in_ready, 1);

        // Single samples: latency and value.
        for (int i = 0; i < 11; i++) begin
            send(vecs[i].x, vecs[i].mode);
            i_in_valid = 1'b0;
            lat = 1;
            while (!o_out_valid && lat < 10) begin
                cyc(acc);
                lat++;
            end
            check($sformatf("vec%0d_latency", i), lat, 3);
            check($sformatf("vec%0d_y", i), o_y, vecs[i].y);
            cyc(acc);
        end

        // Backpressure: fill the pipe with the sink stalled.
        i_out_ready = 1'b0;
        n0 = n_out;
        for (int i = 0; i < 3; i++) send(bp_x[i][7:0], 1'b0);
        i_x = bp_x[3][7:0];
        check("bp_full_in_ready", o_in_ready, 0);
        check("bp_full_out_valid", o_out_valid, 1);
        check("bp_head_y", o_y, 16'h4000);
        for (int k = 0; k < 3; k++) begin
            cyc(acc);
            check("bp_stall_in_ready", o_in_ready, 0);
            check("bp_stall_valid", o_out_valid, 1);
            check("bp_stall_y", o_y, 16'h4000);
        end
        i_out_ready = 1'b1;
        send(bp_x[3][7:0], 1'b0);
        check("bp_full_swap_valid", o_out_valid, 1);
        check("bp_full_swap_in_ready", o_in_ready, 1);
        send(bp_x[4][7:0], 1'b0);
        drain();
        check("bp_count", n_out - n0, 5);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_order%0d", k), out_log[out_log.size() - 5 + k], bp_y[k]);
        end

        // Alternating modes back to back.
        for (int k = 0; k < 4; k++) send(8'h10, k[0]);
        drain();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("alt_y%0d", k), out_log[out_log.size() - 4 + k], alt_y[k]);
        end
        for (int k = 1; k < 4; k++) begin
            check($sformatf("alt_no_bubble%0d", k),
                  out_cyc[out_cyc.size() - 4 + k] - out_cyc[out_cyc.size() - 5 + k], 1);
        end

        // Reset with two samples in flight.
        send(8'h20, 1'b0);
        send(8'h40, 1'b0);
        i_in_valid = 1'b0;
        rst_n = 1'b0;
        cyc(acc);
        check("midrst_out_valid", o_out_valid, 0);
        check("midrst_y", o_y, 0);
        check("midrst_in_ready", o_in_ready, 0);
        rst_n = 1'b1;
        #1;
        check("midrst_release_in_ready", o_in_ready, 1);
        nv = 0;
        for (int k = 0; k < 6; k++) begin
            if (o_out_valid) nv++;
            cyc(acc);
        end
        check("midrst_no_stale", nv, 0);

        // Full sweep in both modes against the reference model.
        for (int m = 0; m < 2; m++) begin
            for (int x = 0; x < 256; x++) send(x[7:0], m[0]);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
